// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes an RV32I instruction plus regfile operands into ALU control and operands.
// Latency: 1 cycle from input acceptance to out_*; full throughput while out_ready=1.
// Backpressure: 2-entry output register + skid; in_ready is registered (!skid_valid), so out_ready never reaches in_ready combinationally.
//
// Ports:
//   clk, rst          - clock and asynchronous active-high reset
//   flush             - synchronous flush, drops output and skid entries and the input of that cycle
//   in_valid/in_ready - upstream handshake; in_instr, in_pc, in_rs1_data, in_rs2_data are the payload
//   out_valid/out_ready - downstream handshake; out_alu_ctrl, out_src1, out_src2, out_pc,
//                       out_is_branch, out_take_on_zero, out_illegal are the decoded entry
//   stat_issued, stat_illegal - transfer counters, live only when ALU_ISSUE_STATS_EN is defined
//
// Optional feature macro: ALU_ISSUE_STATS_EN (undefined: stat ports tied to 0, no counter flops).
module alu_issue_stage #(
   parameter int XLEN   = 32,
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [XLEN-1:0]   in_rs1_data,
   input  logic [XLEN-1:0]   in_rs2_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [3:0]        out_alu_ctrl,
   output logic [XLEN-1:0]   out_src1,
   output logic [XLEN-1:0]   out_src2,
   output logic [XLEN-1:0]   out_pc,
   output logic              out_is_branch,
   output logic              out_take_on_zero,
   output logic              out_illegal,
   output logic [STAT_W-1:0] stat_issued,
   output logic [STAT_W-1:0] stat_illegal
);

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_SLL  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLTU = 4'b0111;
   localparam logic [3:0] ALU_XOR  = 4'b1000;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef struct packed {
      logic [3:0]      alu_ctrl;
      logic [XLEN-1:0] src1;
      logic [XLEN-1:0] src2;
      logic [XLEN-1:0] pc;
      logic            is_branch;
      logic            take_on_zero;
      logic            illegal;
   } entry_t;

   // ------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_u;
   logic        bad;
   entry_t      dec;

   // rs1/rd register indices are resolved upstream; only the read data is used here.
   logic unused_fields;
   assign unused_fields = ^{in_instr[19:15]};

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];
   assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_u  = {in_instr[31:12], 12'b0};

   always_comb begin
      bad              = 1'b0;
      dec              = '0;
      dec.pc           = in_pc;
      dec.src1         = in_rs1_data;
      dec.src2         = in_rs2_data;
      dec.alu_ctrl     = ALU_ADD;
      case (opcode)
         OPC_OP: begin
            if (funct7 == 7'b0000000) begin
               case (funct3)
                  3'b000:  dec.alu_ctrl = ALU_ADD;
                  3'b001:  dec.alu_ctrl = ALU_SLL;
                  3'b010:  dec.alu_ctrl = ALU_SLT;
                  3'b011:  dec.alu_ctrl = ALU_SLTU;
                  3'b100:  dec.alu_ctrl = ALU_XOR;
                  3'b110:  dec.alu_ctrl = ALU_OR;
                  3'b111:  dec.alu_ctrl = ALU_AND;
                  default: bad = 1'b1;   // srl: no shifter-right support in this ALU
               endcase
            end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
               dec.alu_ctrl = ALU_SUB;
            end else begin
               bad = 1'b1;              // sra and any other funct7
            end
         end
         OPC_OP_IMM: begin
            dec.src2 = imm_i;
            case (funct3)
               3'b000:  dec.alu_ctrl = ALU_ADD;
               3'b001:  begin
                  dec.alu_ctrl = ALU_SLL;
                  bad          = (funct7 != 7'b0000000);
               end
               3'b010:  dec.alu_ctrl = ALU_SLT;
               3'b011:  dec.alu_ctrl = ALU_SLTU;
               3'b100:  dec.alu_ctrl = ALU_XOR;
               3'b110:  dec.alu_ctrl = ALU_OR;
               3'b111:  dec.alu_ctrl = ALU_AND;
               default: bad = 1'b1;     // srli/srai
            endcase
         end
         OPC_LOAD:  dec.src2 = imm_i;
         OPC_STORE: dec.src2 = imm_s;
         OPC_LUI: begin
            dec.src1 = '0;
            dec.src2 = imm_u;
         end
         OPC_BRANCH: begin
            dec.is_branch = 1'b1;
            // Branches compare via the ALU zero flag: SUB for equality,
            // SLT/SLTU for ordering (result 0 means "not less than").
            case (funct3)
               3'b000: begin dec.alu_ctrl = ALU_SUB;  dec.take_on_zero = 1'b1; end
               3'b001: begin dec.alu_ctrl = ALU_SUB;  dec.take_on_zero = 1'b0; end
               3'b100: begin dec.alu_ctrl = ALU_SLT;  dec.take_on_zero = 1'b0; end
               3'b101: begin dec.alu_ctrl = ALU_SLT;  dec.take_on_zero = 1'b1; end
               3'b110: begin dec.alu_ctrl = ALU_SLTU; dec.take_on_zero = 1'b0; end
               3'b111: begin dec.alu_ctrl = ALU_SLTU; dec.take_on_zero = 1'b1; end
               default: bad = 1'b1;
            endcase
         end
         default: bad = 1'b1;
      endcase
      // Illegal entries carry a neutral payload so the ALU sees a harmless ADD 0,0.
      if (bad) begin
         dec.alu_ctrl     = ALU_ADD;
         dec.src1         = '0;
         dec.src2         = '0;
         dec.is_branch    = 1'b0;
         dec.take_on_zero = 1'b0;
         dec.illegal      = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Output register + skid entry
   // ------------------------------------------------------------------
   entry_t out_q, out_d;
   entry_t skid_q, skid_d;
   logic   out_valid_q, out_valid_d;
   logic   skid_valid_q, skid_valid_d;
   logic   accept;
   logic   issue;

   assign in_ready = ~skid_valid_q;
   assign accept   = in_valid & in_ready & ~flush;
   assign issue    = out_valid_q & out_ready & ~flush;

   always_comb begin
      out_d        = out_q;
      out_valid_d  = out_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!out_valid_q || out_ready) begin
         // Output slot frees this cycle. A full skid implies in_ready=0,
         // so the skid and a new input never compete for the slot.
         if (skid_valid_q) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_d       = dec;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_d       = dec;
         skid_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q        <= '0;
         out_valid_q  <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
      end else begin
         out_q        <= out_d;
         out_valid_q  <= out_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign out_valid        = out_valid_q;
   assign out_alu_ctrl     = out_q.alu_ctrl;
   assign out_src1         = out_q.src1;
   assign out_src2         = out_q.src2;
   assign out_pc           = out_q.pc;
   assign out_is_branch    = out_q.is_branch;
   assign out_take_on_zero = out_q.take_on_zero;
   assign out_illegal      = out_q.illegal;

   // ------------------------------------------------------------------
   // Statistics
   // ------------------------------------------------------------------
`ifdef ALU_ISSUE_STATS_EN
   logic [STAT_W-1:0] stat_issued_q, stat_issued_d;
   logic [STAT_W-1:0] stat_illegal_q, stat_illegal_d;

   always_comb begin
      stat_issued_d  = stat_issued_q;
      stat_illegal_d = stat_illegal_q;
      if (issue) begin
         stat_issued_d = stat_issued_q + STAT_W'(1);
         if (out_q.illegal) begin
            stat_illegal_d = stat_illegal_q + STAT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_issued_q  <= '0;
         stat_illegal_q <= '0;
      end else begin
         stat_issued_q  <= stat_issued_d;
         stat_illegal_q <= stat_illegal_d;
      end
   end

   assign stat_issued  = stat_issued_q;
   assign stat_illegal = stat_illegal_q;
`else
   logic unused_issue;
   assign unused_issue = issue;
   assign stat_issued  = '0;
   assign stat_illegal = '0;
`endif

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Producer side of the ALU control/operand interface.
- Accepts a fetched RV32I instruction plus register-file read data.
- Decodes it into the 4-bit ALU operation code and the two ALU operands.
- Presents the result through a registered valid/ready stage with a skid buffer, so the execute stage can stall without dropping instructions.
- Sits between decode/regfile read and the ALU.

Parameters:
XLEN, 32, datapath width of operands and pc (only 32 supported)
STAT_W, 16, width of statistics counters (optional feature)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
flush  input  1  synchronous pipeline flush, drops all buffered entries
in_valid  input  1  upstream instruction valid
in_ready  output  1  stage can accept an instruction
in_instr  input  32  instruction word
in_pc  input  XLEN  instruction address
in_rs1_data  input  XLEN  rs1 read value
in_rs2_data  input  XLEN  rs2 read value
out_valid  output  1  decoded entry valid
out_ready  input  1  execute stage accepts entry
out_alu_ctrl  output  4  ALU operation code
out_src1  output  XLEN  ALU operand 1
out_src2  output  XLEN  ALU operand 2
out_pc  output  XLEN  pc of entry
out_is_branch  output  1  entry is a conditional branch
out_take_on_zero  output  1  branch taken when ALU zero==1 (else taken when zero==0)
out_illegal  output  1  instruction not supported
stat_issued  output  STAT_W  entries handed to execute (optional)
stat_illegal  output  STAT_W  illegal entries handed to execute (optional)

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, skid entry empty, in_ready=1.
  - All out_* data fields = 0; stat counters = 0.
- ALU codes:
  - ADD=0000, SUB=0001, AND=0010, OR=0011, SLL=0100, SLT=0101, SLTU=0111, XOR=1000.
- Decode, combinational on input side:
  - OP (0110011): add/sub (funct7[5] selects SUB), and, or, xor, sll, slt, sltu. src1=rs1, src2=rs2.
  - OP-IMM (0010011): addi, andi, ori, xori, slti, sltiu, slli (funct7 must be 0). src2 = sign-extended I-imm.
  - LOAD (0000011) / STORE (0100011): ADD, src1=rs1, src2 = sign-extended I-imm / S-imm.
  - LUI (0110111): ADD, src1=0, src2 = {instr[31:12],12'b0}.
  - BRANCH (1100011): src1=rs1, src2=rs2, out_is_branch=1:
    - beq: SUB, take_on_zero=1; bne: SUB, take_on_zero=0.
    - blt: SLT, take_on_zero=0; bge: SLT, take_on_zero=1.
    - bltu: SLTU, take_on_zero=0; bgeu: SLTU, take_on_zero=1.
- Illegal (out_illegal=1, alu_ctrl=ADD, src1=src2=0, is_branch=0):
  - srl/sra/srli/srai.
  - slli with funct7!=0.
  - OP funct7 other than 0000000 or 0100000 (0100000 is legal only for sub).
  - branch funct3 010/011.
  - Any other opcode.
  - Illegal entries still flow through the handshake.
- Handshake:
  - Input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
  - Latency 1 cycle: an instruction accepted at edge N appears on out_* after edge N.
  - Full throughput, 1 entry/cycle, while out_ready=1.
- Skid buffer:
  - in_ready is registered, equal to !skid_valid (no combinational path from out_ready to in_ready).
  - If the output register is full, not being drained, and an input is accepted, the input goes to the skid entry and in_ready drops next cycle.
  - When the output drains, the skid entry moves to the output register and in_ready returns to 1.
  - Order is strictly preserved.
- Output stability: while out_valid=1 and out_ready=0, all out_* hold constant.
- flush:
  - Has priority over every transfer in that cycle.
  - Next cycle: out_valid=0, skid empty, in_ready=1.
  - The input presented in the flush cycle is discarded.
  - Stat counters are not changed by flushed entries.
- Simultaneous drain+accept with the skid empty: the output register is replaced by the new entry, with no bubble.

Optional Feature:
- Macro: ALU_ISSUE_STATS_EN.
- Defined:
  - stat_issued increments on every output transfer.
  - stat_illegal increments on output transfers with out_illegal=1.
  - Both wrap modulo 2^STAT_W and reset to 0.
- Undefined: both stat ports are tied to 0 and no counter flops are built.

Test Plan:
1. add x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, alu_ctrl=0000, src1=5, src2=7, illegal=0.
2. addi -1 (0xFFF08093), rs1=3 -> alu_ctrl=0000, src2=0xFFFFFFFF; bge (funct3=101) -> alu_ctrl=0101, is_branch=1, take_on_zero=1.
3. Back-to-back instrs A,B,C with out_ready=0 from cycle 1 -> A held on out_*, B in skid, in_ready=0, C not accepted. out_ready=1 -> A, B, C emitted in order with no duplicates.
4. srai (0x4020D093) -> out_illegal=1, alu_ctrl=0000, src1=src2=0; with ALU_ISSUE_STATS_EN, stat_illegal=1 after the transfer.
5. flush while output and skid are full -> next cycle out_valid=0, in_ready=1, stats unchanged.
6. rst asserted mid-stream (asynchronously, between edges) -> out_valid=0 and in_ready=1 immediately; 2^STAT_W+1 issues -> stat_issued=1.
